car_palette_arbiter: RTL and testbench

// - Round-robin arbiter sharing one car_palette lookup among NUM_REQ sprite requesters (player car, opponent cars).
// - Drives the palette's 5-bit colorIdx, captures the combinational Red/Green/Blue and returns them in a registered output stage.
// - Output stage has valid/ready backpressure toward the frame compositor.

---
 rtl/car_palette_arbiter.sv | 162 ++++++++++++++++
 tb/tb_car_palette_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/car_palette_arbiter.sv
// ----------------------------------------------------------------------------
// car_palette_arbiter
//
// Purpose:
//    Round-robin arbiter that shares a single car_palette lookup between
//    NUM_REQ sprite requesters. The granted requester's colour index is driven
//    to the palette, the combinational palette colour is captured on the next
//    clock edge, and it is presented through a registered valid/ready output
//    stage toward the frame compositor. Throughput is one result per cycle;
//    a result popped in the same cycle as a new grant is replaced with no
//    bubble.
//
// Ports:
//    Clk         in   system clock, rising edge
//    Reset       in   synchronous active-high reset
//    req         in   per-requester request flags
//    req_idx     in   packed per-requester palette indices, IDX_W each
//    gnt         out  one-hot combinational grant
//    pal_idx     out  index to car_palette colorIdx (0 when nothing granted)
//    pal_r/g/b   in   palette colour for pal_idx
//    out_valid   out  registered result valid
//    out_ready   in   compositor accepts the result
//    out_id      out  requester that owns the result
//    out_r/g/b   out  registered colour
//    out_transp  out  index-0 transparency flag
//
// Build option:
//    CAR_PAL_TRANSPARENT_EN  when defined, a granted index 0 registers
//                            out_transp=1 with black colour instead of the
//                            palette output. When undefined, out_transp is 0.
// ----------------------------------------------------------------------------
module car_palette_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 5,
   parameter int ID_W    = 2
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [IDX_W-1:0]         pal_idx,
   input  logic [7:0]               pal_r,
   input  logic [7:0]               pal_g,
   input  logic [7:0]               pal_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_id,
   output logic [7:0]               out_r,
   output logic [7:0]               out_g,
   output logic [7:0]               out_b,
   output logic                     out_transp
);

   logic [ID_W-1:0]  r_rr_ptr;
   logic             r_out_valid;
   logic [ID_W-1:0]  r_out_id;
   logic [7:0]       r_out_r;
   logic [7:0]       r_out_g;
   logic [7:0]       r_out_b;

   logic             w_can_accept;
   logic             w_any;
   logic [ID_W-1:0]  w_gnt_id;
   logic [ID_W:0]    w_cand;
   logic [ID_W-1:0]  w_ptr_next;
   logic [7:0]       w_cap_r;
   logic [7:0]       w_cap_g;
   logic [7:0]       w_cap_b;
   logic [IDX_W-1:0] w_idx_slice [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign w_idx_slice[gi] = req_idx[gi*IDX_W +: IDX_W];
      end
   endgenerate

   // The output register can take a new result when it is empty or is being
   // popped this very cycle; that is what gives back-to-back throughput.
   assign w_can_accept = !r_out_valid || out_ready;

   // Search upward from the round-robin pointer, wrapping at NUM_REQ-1.
   // The candidate is one bit wider than an ID so the wrap can be detected.
   always_comb begin
      w_any    = 1'b0;
      w_gnt_id = '0;
      w_cand   = '0;
      if (!Reset && w_can_accept) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
               w_cand = w_cand - (ID_W+1)'(NUM_REQ);
            end
            if (!w_any && req[w_cand[ID_W-1:0]]) begin
               w_any    = 1'b1;
               w_gnt_id = w_cand[ID_W-1:0];
            end
         end
      end
   end

   assign gnt        = w_any ? (NUM_REQ'(1) << w_gnt_id) : '0;
   assign pal_idx    = w_any ? w_idx_slice[w_gnt_id] : '0;
   assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);

`ifdef CAR_PAL_TRANSPARENT_EN
   logic w_idx_zero;
   logic r_out_transp;

   // Index 0 is the sprite's see-through colour: flag it and force black so
   // the compositor never blends a stale palette entry.
   assign w_idx_zero = (pal_idx == '0);
   assign w_cap_r    = w_idx_zero ? 8'h00 : pal_r;
   assign w_cap_g    = w_idx_zero ? 8'h00 : pal_g;
   assign w_cap_b    = w_idx_zero ? 8'h00 : pal_b;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_out_transp <= 1'b0;
      end else if (w_any) begin
         r_out_transp <= w_idx_zero;
      end
   end

   assign out_transp = r_out_transp;
`else
   assign w_cap_r    = pal_r;
   assign w_cap_g    = pal_g;
   assign w_cap_b    = pal_b;
   assign out_transp = 1'b0;
`endif

   // A grant always loads the output stage; otherwise a pop empties it.
   // Reset wins so a result pending at reset never appears.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_rr_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_r     <= 8'h00;
         r_out_g     <= 8'h00;
         r_out_b     <= 8'h00;
      end else if (w_any) begin
         r_rr_ptr    <= w_ptr_next;
         r_out_valid <= 1'b1;
         r_out_id    <= w_gnt_id;
         r_out_r     <= w_cap_r;
         r_out_g     <= w_cap_g;
         r_out_b     <= w_cap_b;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_id    = r_out_id;
   assign out_r     = r_out_r;
   assign out_g     = r_out_g;
   assign out_b     = r_out_b;

endmodule

// File: tb/tb_car_palette_arbiter.sv
// ----------------------------------------------------------------------------
// tb_car_palette_arbiter
//
// Self-checking bench for car_palette_arbiter. A small palette stub answers
// pal_idx combinationally. A transaction-level reference model (pointer,
// output slot) predicts grant and output each cycle; directed steps cover
// reset, single request, round robin, backpressure, index 0 and reset during
// operation, followed by a random phase that obeys the requester protocol.
// ----------------------------------------------------------------------------
module tb_car_palette_arbiter;

   localparam int N  = 4;
   localparam int IW = 5;
   localparam int DW = 2;

   logic            Clk = 1'b0;
   logic            Reset;
   logic [N-1:0]    req;
   logic [N*IW-1:0] req_idx;
   logic [N-1:0]    gnt;
   logic [IW-1:0]   pal_idx;
   logic [7:0]      pal_r, pal_g, pal_b;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_id;
   logic [7:0]      out_r, out_g, out_b;
   logic            out_transp;

   car_palette_arbiter #(.NUM_REQ(N), .IDX_W(IW), .ID_W(DW)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .req        (req),
      .req_idx    (req_idx),
      .gnt        (gnt),
      .pal_idx    (pal_idx),
      .pal_r      (pal_r),
      .pal_g      (pal_g),
      .pal_b      (pal_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_r      (out_r),
      .out_g      (out_g),
      .out_b      (out_b),
      .out_transp (out_transp)
   );

   always #5 Clk = ~Clk;

   // Palette stub: known entries from the car palette, anything else is an
   // arbitrary but deterministic colour.
   function automatic logic [23:0] pal_lut(input logic [IW-1:0] idx);
      case (idx)
         5'd0:    return 24'h430126;
         5'd1:    return 24'hb8b8b8;
         5'd9:    return 24'hfcd90c;
         5'd10:   return 24'h241ca5;
         5'd11:   return 24'h171517;
         5'd12:   return 24'hf1ee99;
         5'd19:   return 24'hee2a23;
         default: return {8'(idx * 29 + 3), 8'(idx * 53 + 7), 8'({3'b0, idx} ^ 8'h5a)};
      endcase
   endfunction

   always_comb {pal_r, pal_g, pal_b} = pal_lut(pal_idx);

   // {transp, r, g, b} expected for a granted index
   function automatic logic [24:0] exp_colour(input logic [IW-1:0] idx);
`ifdef CAR_PAL_TRANSPARENT_EN
      if (idx == '0) return 25'h1000000;
`endif
      return {1'b0, pal_lut(idx)};
   endfunction

   int errors = 0;
   int checks = 0;

   // reference model state
   int          m_ptr    = 0;
   bit          m_valid  = 0;
   int          m_id     = 0;
   logic [24:0] m_col    = '0;
   int          last_eg  = -1;
   logic [N-1:0]  last_gnt;
   logic [IW-1:0] last_pal;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [IW-1:0] idx_of(input int i);
      logic [N*IW-1:0] v;
      v = req_idx;
      return v[i*IW +: IW];
   endfunction

   task automatic set_idx(input int i, input int v);
      req_idx[i*IW +: IW] = IW'(v);
   endtask

   // Which requester should win this cycle: -1 when none.
   function automatic int exp_grant();
      if (Reset) return -1;
      if (m_valid && !out_ready) return -1;
      for (int k = 0; k < N; k++) begin
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   // One clock: check at the falling edge, update the model at the rising
   // edge, return 1 time unit later so the caller can change inputs.
   task automatic cycle();
      int eg;
      @(negedge Clk);
      eg = exp_grant();
      last_gnt = gnt;
      last_pal = pal_idx;
      check("gnt", 32'(gnt), (eg < 0) ? 32'd0 : 32'(1 << eg));
      if (eg >= 0) check("pal_idx", 32'(pal_idx), 32'(idx_of(eg)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         check("out_id", 32'(out_id), 32'(m_id));
         check("out_rgb", {8'h0, out_r, out_g, out_b}, {8'h0, m_col[23:0]});
         check("out_transp", 32'(out_transp), 32'(m_col[24]));
      end
      @(posedge Clk);
      if (Reset) begin
         m_valid = 0;
         m_ptr   = 0;
      end else if (eg >= 0) begin
         m_valid = 1;
         m_id    = eg;
         m_col   = exp_colour(idx_of(eg));
         m_ptr   = (eg + 1) % N;
         $display("grant req=%0d idx=%0d rgb=%06h", eg, idx_of(eg), m_col[23:0]);
      end else if (out_ready) begin
         m_valid = 0;
      end
      last_eg = eg;
      #1;
   endtask

   logic [23:0] rr_col [5];

   initial begin
      rr_col[0] = 24'hfcd90c; rr_col[1] = 24'h241ca5; rr_col[2] = 24'h171517;
      rr_col[3] = 24'hf1ee99; rr_col[4] = 24'hfcd90c;

      // Reset with every requester active
      Reset = 1'b1; req = '1; out_ready = 1'b1; req_idx = '0;
      for (int i = 0; i < N; i++) set_idx(i, 9 + i);
      for (int c = 0; c < 2; c++) begin
         cycle();
         check("rst_gnt", 32'(last_gnt), 32'd0);
         check("rst_valid", 32'(out_valid), 32'd0);
         check("rst_rgb", {8'h0, out_r, out_g, out_b}, 32'd0);
         check("rst_transp", 32'(out_transp), 32'd0);
      end

      // Round robin from requester 0, one-cycle latency
      Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         check("rr_gnt", 32'(last_gnt), 32'(1 << (c % N)));
         check("rr_valid", 32'(out_valid), 32'd1);
         check("rr_id", 32'(out_id), 32'(c % N));
         check("rr_rgb", {8'h0, out_r, out_g, out_b}, {8'h0, rr_col[c]});
      end
      req = '0;
      cycle();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Single request from requester 1
      req = 4'b0010; set_idx(1, 1);
      cycle();
      check("single_gnt", 32'(last_gnt), 32'b0010);
      check("single_pal", 32'(last_pal), 32'd1);
      check("single_id", 32'(out_id), 32'd1);
      check("single_rgb", {8'h0, out_r, out_g, out_b}, 32'hb8b8b8);
      req = '0;
      cycle();

      // Backpressure: result held, no grants until the pop
      out_ready = 1'b0; req = 4'b1000; set_idx(3, 19);
      cycle();
      check("bp_first_gnt", 32'(last_gnt), 32'b1000);
      for (int c = 0; c < 5; c++) begin
         cycle();
         check("bp_hold_gnt", 32'(last_gnt), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_rgb", {8'h0, out_r, out_g, out_b}, 32'hee2a23);
      end
      out_ready = 1'b1;
      cycle();
      check("bp_pop_gnt", 32'(last_gnt), 32'b1000);
      check("bp_pop_valid", 32'(out_valid), 32'd1);
      req = '0;
      cycle();
      check("bp_empty", 32'(out_valid), 32'd0);

      // Index 0
      req = 4'b0001; set_idx(0, 0);
      cycle();
      check("idx0_gnt", 32'(last_gnt), 32'b0001);
`ifdef CAR_PAL_TRANSPARENT_EN
      check("idx0_transp", 32'(out_transp), 32'd1);
      check("idx0_rgb", {8'h0, out_r, out_g, out_b}, 32'h000000);
`else
      check("idx0_transp", 32'(out_transp), 32'd0);
      check("idx0_rgb", {8'h0, out_r, out_g, out_b}, 32'h430126);
`endif
      req = '0;
      cycle();

      // Reset in the cycle after a grant
      req = '1;
      for (int i = 0; i < N; i++) set_idx(i, 9 + i);
      cycle();
      check("mid_gnt", 32'(last_gnt), 32'b0010);
      Reset = 1'b1;
      cycle();
      check("mid_rst_gnt", 32'(last_gnt), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      Reset = 1'b0;
      cycle();
      check("mid_restart_gnt", 32'(last_gnt), 32'b0001);
      check("mid_restart_rgb", {8'h0, out_r, out_g, out_b}, 32'hfcd90c);
      req = '0;
      cycle();

      // Random traffic obeying the requester protocol
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               if (last_eg == i) begin
                  if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                  else set_idx(i, int'($urandom_range(0, 31)));
               end
            end else if ($urandom_range(0, 9) < 4) begin
               req[i] = 1'b1;
               set_idx(i, int'($urandom_range(0, 31)));
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
